// File: rtl/boxcar_accum.sv
// boxcar_accum: running (moving) sum over the last N samples.
// Sits behind the programmable word-delay stage and consumes the aligned
// pair {x[k], x[k-N]}. The sum is maintained incrementally as
// acc += x[k] - x[k-N]. During warm-up the delayed word is ignored, so stale
// delay-line contents never enter the sum. A change of window length restarts
// the block exactly as a reset would.
//
// Pipeline:
//   stage 1 : difference d1 and "window full" flag, fill counter update
//   stage 2 : accumulator, output strobe and full flag
module boxcar_accum #(
    parameter int IW    = 16,
    parameter int LGMEM = 6,
    parameter int OW    = IW + LGMEM
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [LGMEM-1:0] i_navg,
    input  logic             i_ce,
    input  logic [IW-1:0]    i_sample,
    input  logic [IW-1:0]    i_delayed,
    output logic             o_ce,
    output logic [OW-1:0]    o_result,
    output logic             o_full
);

    logic [LGMEM-1:0]       navg_q;
    logic [LGMEM:0]         cnt;
    logic [LGMEM:0]         cnt_inc;
    logic [LGMEM:0]         navg_ext;
    logic signed [IW:0]     d1;
    logic                   full1;
    logic                   ce1;
    logic signed [OW-1:0]   acc;

    logic                   restart;
    logic                   navg_zero;
    logic                   warm;
    logic                   full_next;
    logic signed [IW:0]     sample_x;
    logic signed [IW:0]     delayed_x;
    logic signed [IW:0]     diff_next;

    // Stage-1 combinational terms: warm-up test, full flag and difference.
    always_comb begin
        navg_ext  = {1'b0, navg_q};
        restart   = (i_navg != navg_q);
        navg_zero = (navg_q == '0);
        cnt_inc   = cnt + 1'b1;
        warm      = (cnt < navg_ext);
        full_next = !navg_zero && (cnt_inc >= navg_ext);
        sample_x  = {i_sample[IW-1], i_sample};
        delayed_x = {i_delayed[IW-1], i_delayed};
        diff_next = '0;
        if (!navg_zero) begin
            // Until N samples have been seen the delayed word is junk.
            if (warm)
                diff_next = sample_x;
            else
                diff_next = sample_x - delayed_x;
        end
    end

    // Window-length register; reset and restart both capture the new length.
    always_ff @(posedge i_clk) begin
        if (i_reset || restart)
            navg_q <= i_navg;
    end

    // Stage 1: fill counter (saturates at N), difference and full flag.
    always_ff @(posedge i_clk) begin
        if (i_reset || restart) begin
            cnt   <= '0;
            d1    <= '0;
            full1 <= 1'b0;
            ce1   <= 1'b0;
        end else begin
            ce1 <= i_ce;
            if (i_ce) begin
                d1    <= diff_next;
                full1 <= full_next;
                if (warm)
                    cnt <= cnt_inc;
            end
        end
    end

    // Stage 2: accumulate; width OW guarantees no overflow for legal windows.
    always_ff @(posedge i_clk) begin
        if (i_reset || restart) begin
            acc    <= '0;
            o_full <= 1'b0;
            o_ce   <= 1'b0;
        end else begin
            o_ce <= ce1;
            if (ce1) begin
                acc    <= acc + OW'(d1);
                o_full <= full1;
            end
        end
    end

    assign o_result = acc;

endmodule

// File: tb/tb_boxcar_accum.sv
// tb_boxcar_accum: directed vectors for the boxcar running-sum stage.
// A sample-history model supplies the true x[k-N] once the window is full
// (junk before that) and predicts o_ce/o_result/o_full two clocks later.
module tb_boxcar_accum;

    localparam int IW    = 16;
    localparam int LGMEM = 4;
    localparam int OW    = IW + LGMEM;

    logic             i_clk;
    logic             i_reset;
    logic [LGMEM-1:0] i_navg;
    logic             i_ce;
    logic [IW-1:0]    i_sample;
    logic [IW-1:0]    i_delayed;
    logic             o_ce;
    logic [OW-1:0]    o_result;
    logic             o_full;

    boxcar_accum #(.IW(IW), .LGMEM(LGMEM)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_navg    (i_navg),
        .i_ce      (i_ce),
        .i_sample  (i_sample),
        .i_delayed (i_delayed),
        .o_ce      (o_ce),
        .o_result  (o_result),
        .o_full    (o_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int nq = 0;
    int hist[$];
    int p1_ce = 0;
    int p1_sum = 0;
    int p1_full = 0;
    int exp_ce = 0;
    int exp_res = 0;
    int exp_full = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int o_res_int();
        logic signed [OW-1:0] r;
        r = o_result;
        return int'(r);
    endfunction

    // One clock: drive inputs, advance model at the edge, check #1 later.
    task automatic cyc(input logic rst, input int n, input logic ce, input int x, input int junk);
        int dly;
        int s;
        dly = junk;
        if (!rst && n == nq && nq > 0 && hist.size() == nq)
            dly = hist[0];
        i_reset   = rst;
        i_navg    = n[LGMEM-1:0];
        i_ce      = ce;
        i_sample  = x[IW-1:0];
        i_delayed = dly[IW-1:0];
        @(posedge i_clk);
        if (rst || n != nq) begin
            nq = n;
            hist.delete();
            p1_ce    = 0;
            exp_ce   = 0;
            exp_res  = 0;
            exp_full = 0;
        end else begin
            exp_ce = p1_ce;
            if (p1_ce != 0) begin
                exp_res  = p1_sum;
                exp_full = p1_full;
            end
            p1_ce = int'(ce);
            if (ce) begin
                if (nq == 0) begin
                    p1_sum  = 0;
                    p1_full = 0;
                end else begin
                    hist.push_back(x);
                    if (hist.size() > nq)
                        void'(hist.pop_front());
                    s = 0;
                    foreach (hist[i]) s += hist[i];
                    p1_sum  = s;
                    p1_full = (hist.size() == nq) ? 1 : 0;
                end
            end
        end
        #1;
        chk("o_ce", int'(o_ce), exp_ce);
        chk("o_result", o_res_int(), exp_res);
        chk("o_full", int'(o_full), exp_full);
    endtask

    initial begin
        i_reset = 1'b1; i_navg = '0; i_ce = 1'b0; i_sample = '0; i_delayed = '0;

        // warm-up with junk delayed word, N=4, x=100
        cyc(1, 4, 0, 0, 0);
        cyc(1, 4, 0, 0, 0);
        chk("rst_ce", int'(o_ce), 0);
        chk("rst_result", o_res_int(), 0);
        for (int i = 0; i < 8; i++) cyc(0, 4, 1, 100, 32767);
        cyc(0, 4, 0, 0, 0);
        cyc(0, 4, 0, 0, 0);
        chk("t1_final", o_res_int(), 400);
        chk("t1_full", int'(o_full), 1);

        // most negative samples, N=4
        cyc(1, 4, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 4, 1, -32768, 32767);
        cyc(0, 4, 0, 0, 0);
        cyc(0, 4, 0, 0, 0);
        chk("t2_final", o_res_int(), -131072);

        // strobe every third clock, ramp 1..10, N=3
        cyc(1, 3, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 3, 1, i, 32767);
            cyc(0, 3, 0, 0, 0);
            cyc(0, 3, 0, 0, 0);
        end
        chk("t3_final", o_res_int(), 27);

        // window change 4 -> 2 mid-stream; restart-cycle sample dropped
        cyc(1, 4, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 4, 1, 7, 32767);
        cyc(0, 2, 1, 5, 32767);
        for (int i = 0; i < 3; i++) cyc(0, 2, 1, 5, 32767);
        cyc(0, 2, 0, 0, 0);
        cyc(0, 2, 0, 0, 0);
        chk("t4_final", o_res_int(), 10);
        chk("t4_full", int'(o_full), 1);

        // reset with a sample in flight
        cyc(1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 2, 1, 9, 32767);
        cyc(1, 2, 0, 0, 0);
        chk("t5_ce0", int'(o_ce), 0);
        cyc(0, 2, 0, 0, 0);
        chk("t5_ce1", int'(o_ce), 0);
        chk("t5_result", o_res_int(), 0);
        chk("t5_full", int'(o_full), 0);

        // N=0: strobe passes through, sum stays zero
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++)
            cyc(0, 0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
